mcla20_share_arb: RTL and testbench

- Shares one external 20-bit carry-lookahead adder (20+20 -> 21-bit sum, no carry-in) among NREQ requesters.
- Uses round-robin arbitration with valid/ready handshakes on both the request side and the response side.
- Drives the adder operands combinationally from the granted requester and captures the 21-bit sum with a requester ID tag into a single-entry response register.
- Sits between the partial-product generation units and the shared final-stage adder in the approximate multiplier datapath.

---
 rtl/mcla20_share_arb.sv | 118 +++++++++++
 tb/tb_mcla20_share_arb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcla20_share_arb.sv
// Round-robin front end for one shared 20-bit adder: grants one requester per cycle,
// drives the adder from it and captures the 21-bit sum plus ID in a one-entry response register.
module mcla20_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*20-1:0] req_a,
    input  logic [NREQ*20-1:0] req_b,
    output logic [19:0]       add_a,
    output logic [19:0]       add_b,
    input  logic [20:0]       add_s,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [20:0]       rsp_sum,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       busy_cnt
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // Request side: req_ready is combinational and one-hot for the granted requester.
    // Response side: rsp_valid stays high with stable data until rsp_ready is seen.
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} rsp_state_e;

    rsp_state_e     state_q, state_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [20:0]    sum_q, sum_d;
    logic [IDW-1:0] id_q, id_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [19:0]    add_a_q, add_a_d;
    logic [19:0]    add_b_q, add_b_d;

    logic           can_issue;
    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;
    logic           rsp_hs;

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    always_comb begin
        can_issue = (state_q == EMPTY) || rsp_ready;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (can_issue && !gnt_any && req_valid[wrap_idx(rr_q, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = wrap_idx(rr_q, k);
            end
        end
        if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end

    // Operands freeze on idle cycles so the shared adder does not toggle.
    always_comb begin
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        if (gnt_any) begin
            add_a_d = req_a[gnt_idx*20 +: 20];
            add_b_d = req_b[gnt_idx*20 +: 20];
        end
    end

    assign add_a  = add_a_d;
    assign add_b  = add_b_d;
    assign rsp_hs = (state_q == FULL) && rsp_ready;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sum_d   = sum_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        if (gnt_any) begin
            state_d = FULL;
            sum_d   = add_s;
            id_d    = gnt_idx;
            rr_d    = wrap_idx(gnt_idx, 1);
        end else if (rsp_hs) begin
            state_d = EMPTY;
        end
        if (rsp_hs && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            rr_q    <= '0;
            sum_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            add_a_q <= '0;
            add_b_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            add_a_q <= add_a_d;
            add_b_q <= add_b_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;
    assign busy_cnt  = cnt_q;

endmodule

// File: tb/tb_mcla20_share_arb.sv
// Directed bench for mcla20_share_arb: a request-level model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_mcla20_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*20-1:0] req_a;
    logic [NREQ*20-1:0] req_b;
    logic [19:0]       add_a;
    logic [19:0]       add_b;
    logic [20:0]       add_s;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [20:0]       rsp_sum;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       busy_cnt;

    int n_checks = 0;
    int n_errors = 0;

    mcla20_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_s     (add_s),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy_cnt  (busy_cnt)
    );

    // The shared external adder.
    assign add_s = {1'b0, add_a} + {1'b0, add_b};

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_live = 0;
    bit          m_valid = 0;
    logic [20:0] m_sum = '0;
    int          m_id = 0;
    int          m_rr = 0;
    logic [15:0] m_cnt = '0;
    bit          m_add_known = 0;
    logic [19:0] m_add_a = '0;
    logic [19:0] m_add_b = '0;

    function automatic int model_grant(input logic [3:0] v, input int rr, input bit can);
        if (!can) return -1;
        for (int k = 0; k < NREQ; k++)
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [19:0] op_of(input logic [NREQ*20-1:0] bus, input int i);
        return bus[i*20 +: 20];
    endfunction

    always @(posedge clk) begin
        int g;
        bit hs;
        m_live <= 1'b1;
        if (rst) begin
            m_valid     <= 1'b0;
            m_sum       <= '0;
            m_id        <= 0;
            m_rr        <= 0;
            m_cnt       <= '0;
            m_add_known <= 1'b0;
        end else begin
            g  = model_grant(req_valid, m_rr, !m_valid || rsp_ready);
            hs = m_valid && rsp_ready;
            if (hs && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
            if (g >= 0) begin
                m_valid     <= 1'b1;
                m_sum       <= {1'b0, op_of(req_a, g)} + {1'b0, op_of(req_b, g)};
                m_id        <= g;
                m_rr        <= (g + 1) % NREQ;
                m_add_a     <= op_of(req_a, g);
                m_add_b     <= op_of(req_b, g);
                m_add_known <= 1'b1;
            end else if (hs) begin
                m_valid <= 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        int g;
        logic [3:0] exp_rdy;
        if (m_live) begin
            g = model_grant(req_valid, m_rr, !m_valid || rsp_ready);
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (g >= 0) begin
                check("add_a", 32'(add_a), 32'(op_of(req_a, g)));
                check("add_b", 32'(add_b), 32'(op_of(req_b, g)));
            end else if (m_add_known) begin
                check("add_a_hold", 32'(add_a), 32'(m_add_a));
                check("add_b_hold", 32'(add_b), 32'(m_add_b));
            end
            check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            check("rsp_sum", 32'(rsp_sum), 32'(m_sum));
            check("rsp_id", 32'(rsp_id), 32'(m_id));
            check("busy_cnt", 32'(busy_cnt), 32'(m_cnt));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [19:0] a, input logic [19:0] b);
        req_a[i*20 +: 20] = a;
        req_b[i*20 +: 20] = b;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset held for two cycles.
        step();
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        check("rst_busy_cnt", 32'(busy_cnt), 32'd0);
        step();

        // Single request with carry-out.
        rst = 1'b0;
        req_valid = 4'b0001;
        set_req(0, 20'hFFFFF, 20'h00001);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t1_req_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        @(negedge clk);
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_sum", 32'(rsp_sum), 32'h100000);
        check("t1_rsp_id", 32'(rsp_id), 32'd0);
        step();
        @(negedge clk);
        check("t1_busy_cnt", 32'(busy_cnt), 32'd1);
        check("t1_drained", 32'(rsp_valid), 32'd0);

        // Fair rotation from a fresh pointer.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 20'(i), 20'd10);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 7) req_valid = '0;
            @(negedge clk);
            check("rot_valid", 32'(rsp_valid), 32'd1);
            check("rot_id", 32'(rsp_id), 32'(k % 4));
            check("rot_sum", 32'(rsp_sum), 32'(10 + (k % 4)));
        end

        // Backpressure with requester 2 holding the response register.
        req_valid = 4'b0100;
        set_req(2, 20'h12345, 20'h54321);
        step();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_sum", 32'(rsp_sum), 32'h066666);
            check("bp_id", 32'(rsp_id), 32'd2);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", 32'(req_ready), 32'b1000);
        step();

        // Sparse requests after a grant to requester 3.
        req_valid = 4'b0101;
        @(negedge clk);
        check("wrap_g0", 32'(req_ready), 32'b0001);
        step();
        @(negedge clk);
        check("wrap_g1", 32'(req_ready), 32'b0100);
        step();
        @(negedge clk);
        check("wrap_g2", 32'(req_ready), 32'b0001);
        step();

        // Reset while a response is pending.
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("mid_full", 32'(rsp_valid), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_busy_cnt", 32'(busy_cnt), 32'd0);
        check("mid_first_grant", 32'(req_ready), 32'b0001);
        step();

        // Saturation of the completion counter.
        req_valid = 4'b0001;
        set_req(0, 20'h00003, 20'h00004);
        for (int k = 0; k < 65545; k++) step();
        @(negedge clk);
        check("sat_busy_cnt", 32'(busy_cnt), 32'hFFFF);
        step();
        @(negedge clk);
        check("sat_busy_hold", 32'(busy_cnt), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
